upower_decode_queue: RTL and testbench



---
 rtl/upower_decode_queue_pkg.sv | 55 +++++
 rtl/upower_decode_queue_if.sv | 56 +++++
 rtl/upower_field_decode.sv | 63 ++++++
 rtl/upower_decode_queue.sv | 76 +++++++
 tb/tb_upower_decode_queue.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/upower_decode_queue_pkg.sv
// Shared types for the uPower decode queue: format enum, opcode constants and the decoded entry.
// Purpose: types only. Latency: n/a. Backpressure: n/a.
package upower_decode_pkg;

    typedef enum logic [2:0] {
        FMT_XO  = 3'd0,
        FMT_X   = 3'd1,
        FMT_D   = 3'd2,
        FMT_B   = 3'd3,
        FMT_I   = 3'd4,
        FMT_DS  = 3'd5,
        FMT_ILL = 3'd6
    } fmt_e;

    localparam logic [5:0] OP_X31  = 6'd31;
    localparam logic [5:0] OP_B    = 6'd19;
    localparam logic [5:0] OP_I    = 6'd18;
    localparam logic [5:0] OP_DS58 = 6'd58;
    localparam logic [5:0] OP_DS62 = 6'd62;

    localparam logic [8:0] XO_ADD  = 9'd266;
    localparam logic [8:0] XO_SUBF = 9'd40;

    typedef struct packed {
        fmt_e        fmt;
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  bo;
        logic [4:0]  bi;
        logic [9:0]  xo;
        logic        oe;
        logic        rc;
        logic        aa;
        logic        lk;
        logic [15:0] si;
        logic [13:0] bd;
        logic [13:0] ds;
        logic [23:0] li;
        logic [1:0]  xods;
`ifdef DECODE_ILLEGAL_EN
        logic        illegal;
`endif
    } dec_t;

    function automatic logic is_d_op(input logic [5:0] op);
        case (op)
            6'd14, 6'd15, 6'd24, 6'd26, 6'd28, 6'd32, 6'd34,
            6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44: is_d_op = 1'b1;
            default:                                   is_d_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/upower_decode_queue_if.sv
// Handshake and decoded-field bundle between fetch, the decode queue and issue.
// Purpose: port grouping. Latency: n/a. Backpressure: valid/ready on both sides.
interface upower_decode_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_fmt;
    logic [5:0]       out_opcode;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [4:0]       out_bo;
    logic [4:0]       out_bi;
    logic [9:0]       out_xo;
    logic             out_oe;
    logic             out_rc;
    logic             out_aa;
    logic             out_lk;
    logic [15:0]      out_si;
    logic [13:0]      out_bd;
    logic [13:0]      out_ds;
    logic [23:0]      out_li;
    logic [1:0]       out_xods;
`ifdef DECODE_ILLEGAL_EN
    logic             out_illegal;
`endif
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_fmt, out_opcode, out_rd, out_rs, out_rt,
               out_bo, out_bi, out_xo, out_oe, out_rc, out_aa, out_lk, out_si,
               out_bd, out_ds, out_li, out_xods,
`ifdef DECODE_ILLEGAL_EN
               out_illegal,
`endif
               count
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_fmt, out_opcode, out_rd, out_rs, out_rt,
               out_bo, out_bi, out_xo, out_oe, out_rc, out_aa, out_lk, out_si,
               out_bd, out_ds, out_li, out_xods,
`ifdef DECODE_ILLEGAL_EN
               out_illegal,
`endif
               count
    );
endinterface

// File: rtl/upower_field_decode.sv
// Classifies a raw instruction word and extracts its format fields, zeroing the rest.
// Latency: combinational. Backpressure: none.
module upower_field_decode
    import upower_decode_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);
    logic [5:0] op;
    logic [8:0] sub;

    assign op  = instr[31:26];
    assign sub = instr[9:1];

    always_comb begin
        dec        = '0;
        dec.opcode = op;
        if (op == OP_X31) begin
            dec.rd = instr[25:21];
            dec.rs = instr[20:16];
            dec.rt = instr[15:11];
            dec.rc = instr[0];
            if (sub == XO_ADD || sub == XO_SUBF) begin
                dec.fmt = FMT_XO;
                dec.xo  = {1'b0, instr[9:1]};
                dec.oe  = instr[10];
            end else begin
                dec.fmt = FMT_X;
                dec.xo  = instr[10:1];
            end
        end else if (is_d_op(op)) begin
            dec.fmt = FMT_D;
            dec.rd  = instr[25:21];
            dec.rs  = instr[20:16];
            dec.si  = instr[15:0];
        end else if (op == OP_B) begin
            dec.fmt = FMT_B;
            dec.bo  = instr[25:21];
            dec.bi  = instr[20:16];
            dec.bd  = instr[15:2];
            dec.aa  = instr[1];
            dec.lk  = instr[0];
        end else if (op == OP_I) begin
            dec.fmt = FMT_I;
            dec.li  = instr[25:2];
            dec.aa  = instr[1];
            dec.lk  = instr[0];
`ifdef DECODE_ILLEGAL_EN
        end else if (op != OP_DS58 && op != OP_DS62) begin
            // Illegal words carry no fields at all, opcode included.
            dec.fmt     = FMT_ILL;
            dec.opcode  = '0;
            dec.illegal = 1'b1;
`endif
        end else begin
            dec.fmt  = FMT_DS;
            dec.rd   = instr[25:21];
            dec.rs   = instr[20:16];
            dec.ds   = instr[15:2];
            dec.xods = instr[1:0];
        end
    end
endmodule

// File: rtl/upower_decode_queue.sv
// Buffered uPower decode stage: DEPTH-entry circular queue of pre-decoded instructions (DECODE_ILLEGAL_EN adds ILL format).
// Latency 1 cycle push-to-head; in_ready drops when full or flushing, no pass-through; head held while !out_ready.
module upower_decode_queue
    import upower_decode_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input logic                        clk,
    input logic                        rst,
    input logic                        flush,
    upower_decode_queue_if.slave       bus
);
    localparam int PTR_W = $clog2(DEPTH);

    dec_t             mem [DEPTH];
    dec_t             wr_dec;
    dec_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    upower_field_decode u_dec (
        .instr (bus.in_instr),
        .dec   (wr_dec)
    );

    assign bus.in_ready  = !rst && !flush && (count != CNT_W'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dec;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is never cleared; the empty-queue mask keeps stale entries off the outputs.
    assign head = bus.out_valid ? mem[rd_ptr] : '0;

    assign bus.out_fmt    = head.fmt;
    assign bus.out_opcode = head.opcode;
    assign bus.out_rd     = head.rd;
    assign bus.out_rs     = head.rs;
    assign bus.out_rt     = head.rt;
    assign bus.out_bo     = head.bo;
    assign bus.out_bi     = head.bi;
    assign bus.out_xo     = head.xo;
    assign bus.out_oe     = head.oe;
    assign bus.out_rc     = head.rc;
    assign bus.out_aa     = head.aa;
    assign bus.out_lk     = head.lk;
    assign bus.out_si     = head.si;
    assign bus.out_bd     = head.bd;
    assign bus.out_ds     = head.ds;
    assign bus.out_li     = head.li;
    assign bus.out_xods   = head.xods;
`ifdef DECODE_ILLEGAL_EN
    assign bus.out_illegal = head.illegal;
`endif
    assign bus.count      = count;
endmodule

// File: tb/tb_upower_decode_queue.sv
// Directed bench for upower_decode_queue: hand-decoded vectors, fill/drain order, flush and reset.
module tb_upower_decode_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    upower_decode_queue_if #(.DEPTH(DEPTH)) bus ();

    upower_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        #2;
        check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_fmt", 32'(bus.out_fmt), 32'd0);
        check("rst_si", 32'(bus.out_si), 32'd0);
`ifdef DECODE_ILLEGAL_EN
        check("rst_illegal", 32'(bus.out_illegal), 32'd0);
`endif

        // addo. r3,r4,r5
        push_one(32'h7C642E15);
        check("addo_valid", 32'(bus.out_valid), 32'd1);
        check("addo_fmt", 32'(bus.out_fmt), 32'd0);
        check("addo_opcode", 32'(bus.out_opcode), 32'd31);
        check("addo_rd", 32'(bus.out_rd), 32'd3);
        check("addo_rs", 32'(bus.out_rs), 32'd4);
        check("addo_rt", 32'(bus.out_rt), 32'd5);
        check("addo_oe", 32'(bus.out_oe), 32'd1);
        check("addo_xo", 32'(bus.out_xo), 32'd266);
        check("addo_rc", 32'(bus.out_rc), 32'd1);
        check("addo_si", 32'(bus.out_si), 32'd0);
        check("addo_li", 32'(bus.out_li), 32'd0);
        check("addo_bd", 32'(bus.out_bd), 32'd0);
        // Head must hold while out_ready is low.
        step();
        check("addo_hold_rd", 32'(bus.out_rd), 32'd3);
        pop_one();
        check("addo_popped_count", 32'(bus.count), 32'd0);
        check("empty_fields_zero", 32'(bus.out_rd), 32'd0);

        // addi r1,r2,-1
        push_one(32'h3822FFFF);
        check("addi_fmt", 32'(bus.out_fmt), 32'd2);
        check("addi_rd", 32'(bus.out_rd), 32'd1);
        check("addi_rs", 32'(bus.out_rs), 32'd2);
        check("addi_si", 32'(bus.out_si), 32'hFFFF);
        check("addi_xo", 32'(bus.out_xo), 32'd0);
        check("addi_rt", 32'(bus.out_rt), 32'd0);
        // Push and pop together: count stays at 1, head becomes bl.
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h48000041;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("pushpop_count", 32'(bus.count), 32'd1);
        check("bl_fmt", 32'(bus.out_fmt), 32'd4);
        check("bl_li", 32'(bus.out_li), 32'h000010);
        check("bl_aa", 32'(bus.out_aa), 32'd0);
        check("bl_lk", 32'(bus.out_lk), 32'd1);
        check("bl_rd", 32'(bus.out_rd), 32'd0);
        pop_one();

        // Opcode 19 branch: bo=4 bi=5 bd=5 aa=1 lk=0
        push_one(32'h4C850016);
        check("b_fmt", 32'(bus.out_fmt), 32'd3);
        check("b_bo", 32'(bus.out_bo), 32'd4);
        check("b_bi", 32'(bus.out_bi), 32'd5);
        check("b_bd", 32'(bus.out_bd), 32'd5);
        check("b_aa", 32'(bus.out_aa), 32'd1);
        check("b_lk", 32'(bus.out_lk), 32'd0);
        check("b_rd", 32'(bus.out_rd), 32'd0);
        pop_one();

        // Opcode 31, sub-op 20 -> X with full 10-bit xo
        push_one(32'h7C000028);
        check("x_fmt", 32'(bus.out_fmt), 32'd1);
        check("x_xo", 32'(bus.out_xo), 32'd20);
        check("x_oe", 32'(bus.out_oe), 32'd0);
        pop_one();

        // Opcode 31, sub-op 40 -> XO
        push_one(32'h7C000050);
        check("xo40_fmt", 32'(bus.out_fmt), 32'd0);
        check("xo40_xo", 32'(bus.out_xo), 32'd40);
        pop_one();

        // Opcode 58 -> DS in both builds
        push_one(32'hE8221235);
        check("ds_fmt", 32'(bus.out_fmt), 32'd5);
        check("ds_rd", 32'(bus.out_rd), 32'd1);
        check("ds_rs", 32'(bus.out_rs), 32'd2);
        check("ds_ds", 32'(bus.out_ds), 32'h48D);
        check("ds_xods", 32'(bus.out_xods), 32'd1);
        check("ds_si", 32'(bus.out_si), 32'd0);
        pop_one();

        // Fill past DEPTH with out_ready low; word i carries si=i.
        for (int i = 0; i < DEPTH + 2; i++) begin
            check($sformatf("fill_rdy_%0d", i), 32'(bus.in_ready), (i < DEPTH) ? 32'd1 : 32'd0);
            push_one(32'h38220000 | 32'(i));
        end
        check("full_count", 32'(bus.count), 32'(DEPTH));
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        pop_one();
        check("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
        check("after_pop_count", 32'(bus.count), 32'(DEPTH - 1));
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("drain_si_%0d", i), 32'(bus.out_si), 32'(i));
            pop_one();
        end
        check("drained_valid", 32'(bus.out_valid), 32'd0);
        // out_ready while empty must not underflow the count
        pop_one();
        check("empty_pop_count", 32'(bus.count), 32'd0);

        // Refill, then flush with a word offered in the same cycle.
        for (int i = 0; i < DEPTH; i++) push_one(32'h38220100 | 32'(i));
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h3822ABCD;
        #1;
        check("flush_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_si", 32'(bus.out_si), 32'd0);
        push_one(32'h38220077);
        check("post_flush_count", 32'(bus.count), 32'd1);
        check("post_flush_si", 32'(bus.out_si), 32'h77);
        pop_one();

        push_one(32'h00000000);
`ifdef DECODE_ILLEGAL_EN
        check("zero_fmt", 32'(bus.out_fmt), 32'd6);
        check("zero_illegal", 32'(bus.out_illegal), 32'd1);
`else
        check("zero_fmt", 32'(bus.out_fmt), 32'd5);
        check("zero_ds", 32'(bus.out_ds), 32'd0);
        check("zero_xods", 32'(bus.out_xods), 32'd0);
`endif
        check("zero_valid", 32'(bus.out_valid), 32'd1);

        // Reset mid-stream drops the entry.
        push_one(32'h3822FFFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_count", 32'(bus.count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
